// File: rtl/sr_latch_ctrl_if.sv
// Signal bundle between the SR latch controller, its two requesters and the shared latch.
// The master side is the environment; the slave side is the controller.
interface sr_latch_ctrl_if;
    logic [1:0] req;
    logic [1:0] op;
    logic       q;
    logic       qb;
    logic       s;
    logic       r;
    logic [1:0] ack;
    logic       err;
    logic       busy;

    modport master (
        output req, op, q, qb,
        input  s, r, ack, err, busy
    );

    modport slave (
        input  req, op, q, qb,
        output s, r, ack, err, busy
    );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Arbitrates two requesters onto one shared SR latch: pulses s or r for PW cycles, waits up
// to TMO cycles for q/qb to settle, then acknowledges the requester with an error flag.
module sr_latch_ctrl #(
    parameter int unsigned PW  = 4,
    parameter int unsigned TMO = 8
) (
    input logic            clk,
    input logic            rst,
    sr_latch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPulse, StSettle, StAck} state_e;

    localparam logic [3:0] PwLast  = 4'(PW - 1);
    localparam logic [3:0] TmoLast = 4'(TMO - 1);

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       gnt_q, gnt_d;
    logic       op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic [1:0] ack_q, ack_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       win;
    logic       target;
    logic       matched;
    logic       timeout;

    // A lone request wins outright; with both pending the pointer names the winner.
    assign win     = bus.req[1] & (~bus.req[0] | ptr_q);
    assign target  = (state_q == StIdle) ? bus.op[win] : op_q;
    // Both rails must agree, so a forbidden q == qb state never counts as settled.
    assign matched = (bus.q == target) && (bus.qb != target);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req != 2'b00) begin
                    gnt_d   = win;
                    op_d    = bus.op[win];
                    ptr_d   = ~win;
                    cnt_d   = 4'd0;
                    state_d = matched ? StAck : StPulse;
                end
            end
            StPulse: begin
                if (cnt_q == PwLast) begin
                    cnt_d   = 4'd0;
                    state_d = StSettle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSettle: begin
                if (matched) begin
                    state_d = StAck;
                end else if (cnt_q == TmoLast) begin
                    timeout = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        s_d    = (state_d == StPulse) && op_d;
        r_d    = (state_d == StPulse) && !op_d;
        ack_d  = 2'b00;
        err_d  = 1'b0;
        busy_d = (state_d != StIdle);
        if (state_d == StAck) begin
            ack_d = gnt_d ? 2'b10 : 2'b01;
            err_d = timeout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            op_q    <= 1'b0;
            cnt_q   <= 4'd0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.r    = r_q;
    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: table of single operations against a delayed latch model,
// hand-written contention and reset sequences, and a random run against a timeline model.
module tb_sr_latch_ctrl;

    localparam int PW  = 4;
    localparam int TMO = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Latch model: 0 = stuck, otherwise follows the first drive seen after dly cycles.
    int   lat_dly;
    int   lat_age;
    logic lat_set;

    sr_latch_ctrl_if bus ();

    sr_latch_ctrl #(
        .PW (PW),
        .TMO(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] op;
        logic       q0;
        logic       qb0;
        int         dly;
        logic       drop;
        logic [1:0] eack;
        logic       eerr;
        int         elat;
        int         es;
        int         er;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("s_r_exclusive", 32'(bus.s & bus.r), 32'd0);
        if (lat_dly != 0) begin
            if (lat_age == 0 && (bus.s || bus.r)) begin
                lat_age = 1;
                lat_set = bus.s;
            end else if (lat_age != 0) begin
                lat_age++;
                if (lat_age == lat_dly + 1) begin
                    bus.q  = lat_set;
                    bus.qb = !lat_set;
                end
            end
        end
        if (bus.ack != 2'b00) lat_age = 0;
    endtask

    task automatic reset_dut();
        bus.req = 2'b00;
        rst     = 1'b1;
        #1;
        check("reset_outputs", 32'({bus.s, bus.r, bus.ack, bus.err, bus.busy}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int   n;
        int   sc;
        int   rc;
        logic got;
        logic [1:0] ack_seen;
        logic err_seen;
        bus.q    = v.q0;
        bus.qb   = v.qb0;
        bus.op   = v.op;
        bus.req  = v.req;
        lat_dly  = v.dly;
        lat_age  = 0;
        n        = 0;
        sc       = 0;
        rc       = 0;
        got      = 1'b0;
        ack_seen = 2'b00;
        err_seen = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (bus.s) sc++;
            if (bus.r) rc++;
            if (n == 1 && v.drop) begin
                bus.req = 2'b00;
                bus.op  = ~v.op;
            end
            if (bus.ack != 2'b00) begin
                got      = 1'b1;
                ack_seen = bus.ack;
                err_seen = bus.err;
                bus.req  = 2'b00;
            end
        end
        check($sformatf("vec%0d_ack", idx), 32'(ack_seen), 32'(v.eack));
        check($sformatf("vec%0d_err", idx), 32'(err_seen), 32'(v.eerr));
        check($sformatf("vec%0d_latency", idx), 32'(n), 32'(v.elat));
        check($sformatf("vec%0d_s_cycles", idx), 32'(sc), 32'(v.es));
        check($sformatf("vec%0d_r_cycles", idx), 32'(rc), 32'(v.er));
        tick();
        check($sformatf("vec%0d_idle_after", idx), 32'({bus.ack, bus.err, bus.busy}), 32'd0);
    endtask

    initial begin
        int   sc[2];
        int   rc[2];
        logic [1:0] ackseq[2];
        int   nack;
        int   n;
        // Random-run reference: timeline of the current operation relative to its grant edge.
        logic has_op, red, tmo, ptr, g, opv, mq, mqb;
        logic [1:0] mreq, mop;
        int   kg, ack_c, c;
        logic live, pulse;
        logic [5:0] exp_v;

        checks  = 0;
        errors  = 0;
        lat_dly = 0;
        lat_age = 0;
        lat_set = 1'b0;
        rst     = 1'b1;
        bus.req = 2'b00;
        bus.op  = 2'b00;
        bus.q   = 1'b0;
        bus.qb  = 1'b1;

        //        req    op     q0    qb0   dly drop  eack   eerr  lat s  r
        vecs[0]  = '{2'b01, 2'b01, 1'b0, 1'b1, 1,  1'b0, 2'b01, 1'b0, 6,  4, 0};
        vecs[1]  = '{2'b01, 2'b00, 1'b1, 1'b0, 1,  1'b0, 2'b01, 1'b0, 6,  0, 4};
        vecs[2]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1,  1'b0, 2'b10, 1'b0, 1,  0, 0};
        vecs[3]  = '{2'b01, 2'b00, 1'b0, 1'b1, 1,  1'b0, 2'b01, 1'b0, 1,  0, 0};
        vecs[4]  = '{2'b01, 2'b01, 1'b0, 1'b1, 0,  1'b0, 2'b01, 1'b1, 13, 4, 0};
        vecs[5]  = '{2'b10, 2'b00, 1'b1, 1'b1, 0,  1'b0, 2'b10, 1'b1, 13, 0, 4};
        vecs[6]  = '{2'b10, 2'b00, 1'b0, 1'b0, 0,  1'b0, 2'b10, 1'b1, 13, 0, 4};
        vecs[7]  = '{2'b01, 2'b01, 1'b0, 1'b1, 11, 1'b0, 2'b01, 1'b0, 13, 4, 0};
        vecs[8]  = '{2'b10, 2'b10, 1'b0, 1'b1, 12, 1'b0, 2'b10, 1'b1, 13, 4, 0};
        vecs[9]  = '{2'b10, 2'b10, 1'b0, 1'b1, 1,  1'b1, 2'b10, 1'b0, 6,  4, 0};
        vecs[10] = '{2'b01, 2'b00, 1'b1, 1'b0, 5,  1'b0, 2'b01, 1'b0, 7,  0, 4};

        reset_dut();
        for (int i = 0; i < 11; i++) run_op(i, vecs[i]);

        // Contention with both requests held and the pointer fresh from reset.
        reset_dut();
        bus.q   = 1'b1;
        bus.qb  = 1'b0;
        lat_dly = 1;
        lat_age = 0;
        bus.op  = 2'b10;
        bus.req = 2'b11;
        sc      = '{0, 0};
        rc      = '{0, 0};
        ackseq  = '{2'b00, 2'b00};
        nack    = 0;
        n       = 0;
        while (nack < 2 && n < 60) begin
            tick();
            n++;
            if (bus.s) sc[nack]++;
            if (bus.r) rc[nack]++;
            if (bus.ack != 2'b00) begin
                ackseq[nack] = bus.ack;
                bus.req      = bus.req & ~bus.ack;
                nack++;
            end
        end
        check("cont_ack_count", 32'(nack), 32'd2);
        check("cont_first_ack", 32'(ackseq[0]), 32'h1);
        check("cont_second_ack", 32'(ackseq[1]), 32'h2);
        check("cont_first_r", 32'(rc[0]), 32'(PW));
        check("cont_first_s", 32'(sc[0]), 32'd0);
        check("cont_second_s", 32'(sc[1]), 32'(PW));
        check("cont_second_r", 32'(rc[1]), 32'd0);
        bus.req = 2'b00;
        tick();

        // Reset during the second s cycle of a pulse.
        bus.q   = 1'b0;
        bus.qb  = 1'b1;
        lat_dly = 0;
        bus.op  = 2'b01;
        bus.req = 2'b01;
        tick();
        tick();
        check("pulse_before_rst", 32'(bus.s), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_pulse", 32'({bus.s, bus.r, bus.ack, bus.err, bus.busy}), 32'd0);
        bus.req = 2'b11;
        bus.op  = 2'b11;
        bus.q   = 1'b1;
        bus.qb  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("no_ack_in_rst", 32'({bus.ack, bus.busy}), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_grant", 32'(bus.ack), 32'h1);
        bus.req = 2'b00;
        tick();

        // Random stimulus against the timeline model.
        reset_dut();
        lat_dly = 0;
        has_op  = 1'b0;
        red     = 1'b0;
        tmo     = 1'b0;
        ptr     = 1'b0;
        g       = 1'b0;
        opv     = 1'b0;
        kg      = 0;
        ack_c   = -1;
        for (int e = 0; e < 3000; e++) begin
            mreq   = 2'($urandom_range(0, 3));
            mop    = 2'($urandom_range(0, 3));
            {mq, mqb} = 2'($urandom_range(0, 3));
            bus.req = mreq;
            bus.op  = mop;
            bus.q   = mq;
            bus.qb  = mqb;
            tick();
            if ((!has_op || (ack_c >= 0 && e > ack_c)) && mreq != 2'b00) begin
                g      = (mreq == 2'b11) ? ptr : mreq[1];
                ptr    = !g;
                opv    = mop[g];
                kg     = e;
                has_op = 1'b1;
                tmo    = 1'b0;
                red    = (mq == opv) && (mqb != opv);
                ack_c  = red ? e + 1 : -1;
            end else if (has_op && ack_c < 0 && e >= kg + PW + 1) begin
                if ((mq == opv) && (mqb != opv)) begin
                    ack_c = e + 1;
                end else if (e == kg + PW + TMO) begin
                    ack_c = e + 1;
                    tmo   = 1'b1;
                end
            end
            c     = e + 1;
            live  = has_op && c > kg && (ack_c < 0 || c <= ack_c);
            pulse = has_op && !red && c >= kg + 1 && c <= kg + PW;
            exp_v = {pulse && opv, pulse && !opv, 2'b00, 1'b0, live};
            if (has_op && c == ack_c) begin
                exp_v[3:2] = g ? 2'b10 : 2'b01;
                exp_v[1]   = tmo;
            end
            check($sformatf("random_cycle%0d", e),
                  32'({bus.s, bus.r, bus.ack, bus.err, bus.busy}), 32'(exp_v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 Parameter PW, default 4: width of the s/r drive pulse in clock cycles (1..15).
REQ-002 Parameter TMO, default 8: maximum settle cycles allowed for latch outputs after the pulse (1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester operation request; req[i] is held high until ack[i].
REQ-006 op  input  2  per-requester operation; op[i]=1 means set (q->1) and op[i]=0 means reset (q->0); sampled at grant.
REQ-007 q  input  1  latch true output, fed back from the shared SR latch.
REQ-008 qb  input  1  latch complement output, fed back from the shared SR latch.
REQ-009 s  output  1  set drive to the shared latch; registered.
REQ-010 r  output  1  reset drive to the shared latch; registered.
REQ-011 ack  output  2  one-cycle completion pulse to requester i.
REQ-012 err  output  1  valid with ack; 1 means the latch did not reach the requested state within TMO cycles.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, PULSE, SETTLE and ACK; state and all outputs are registered.
REQ-015 In IDLE with any req bit high at edge k, the FSM SHALL grant one requester, latch its op, and leave IDLE at edge k.
REQ-016 Arbitration SHALL be round-robin with a 1-bit pointer that names the favoured requester.
- Only one req high: that requester wins.
- Both req high: the requester named by the pointer wins.
- The pointer moves to the other requester on each grant.
REQ-017 Redundant op: if at grant q==op and qb==~op, the FSM SHALL go directly to ACK with err=0, so ack is high in cycle k+1 and no pulse is driven.
REQ-018 Otherwise the FSM SHALL enter PULSE and drive s=1 (op=1) or r=1 (op=0) for exactly PW cycles, k+1 through k+PW.
REQ-019 s and r SHALL never be high in the same cycle, under any input sequence.
REQ-020 After PULSE the FSM SHALL enter SETTLE with s=r=0 and a settle counter cleared to 0.
REQ-021 In SETTLE, when q==op and qb==~op, the FSM SHALL go to ACK with err=0.
REQ-022 In SETTLE, if the counter reaches TMO without that match, the FSM SHALL go to ACK with err=1.
REQ-023 Latency SHALL be as follows.
- Best case: ack in cycle k+PW+2.
- Worst case: ack in cycle k+PW+TMO+1.
REQ-024 In ACK, ack[grant] and err SHALL be high for exactly one cycle; the FSM then returns to IDLE.
REQ-025 A new grant SHALL be made no earlier than the cycle after ACK, so at least one IDLE cycle separates operations.
REQ-026 Deassertion of req[grant] after grant SHALL be ignored: the operation completes and is still acknowledged.
REQ-027 Changes on op after grant SHALL be ignored.
REQ-028 ack bits other than the granted one SHALL stay 0; err SHALL be 0 whenever ack is 0.
REQ-029 A forbidden latch state (q==qb) during SETTLE SHALL count as not matched.

Reset
REQ-030 On rst=1, independent of clk, the block SHALL immediately force the following values.
- state=IDLE, pointer=0, settle counter=0.
- s=0, r=0, ack=00, err=0, busy=0.
REQ-031 Reset mid-operation SHALL abort the operation without any ack.
REQ-032 After rst falls, the first grant SHALL occur on the first clk edge with req nonzero.

Verification
REQ-033 The bench SHALL cover the scenario: set from reset. q=0, qb=1; req=01, op[0]=1; latch model responds 1 cycle after s -> s high for 4 cycles, then ack=01 and err=0, with ack 6 cycles after grant.
REQ-034 The bench SHALL cover the scenario: contention. req=11 held, op=10, pointer=0 -> requester 0 served first with r pulses; then requester 1 with s pulses; the ack order is 01 then 10.
REQ-035 The bench SHALL cover the scenario: redundant op. q=1, qb=0; req=10, op[1]=1 -> no s/r pulse, and ack=10 with err=0 in the cycle after grant.
REQ-036 The bench SHALL cover the scenario: stuck latch. q, qb held at 0,1; a set is requested -> after PW+TMO settle, ack with err=1, s low throughout SETTLE.
REQ-037 The bench SHALL cover the scenario: reset mid-PULSE. rst asserted in the second s cycle -> s=0 immediately, no ack, busy=0; a new req after release is granted to requester 0.
REQ-038 Every scenario SHALL include an assertion that s&r is never 1.
